// File: rtl/i2s_rx_stereo_if.sv
// rtl/i2s_rx_stereo_if.sv - I2S receiver pin and sample-output bundle
// master: receiver side (samples mic_data/lrcl_clk, drives the sample outputs)
// slave : source/consumer side (drives the pins, observes the sample outputs)
//   mic_data        serial data pin
//   lrcl_clk        word select; low = left slot, high = right slot
//   left_out        last accepted left sample
//   right_out       last accepted right sample
//   data_valid_out  one-cycle pulse: new pair on left_out/right_out
//   frame_error_out one-cycle pulse: pair discarded on a slot-length fault
interface i2s_rx_stereo_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                    mic_data;
  logic                    lrcl_clk;
  logic [SAMPLE_WIDTH-1:0] left_out;
  logic [SAMPLE_WIDTH-1:0] right_out;
  logic                    data_valid_out;
  logic                    frame_error_out;

  modport master (
    input  mic_data,
    input  lrcl_clk,
    output left_out,
    output right_out,
    output data_valid_out,
    output frame_error_out
  );

  modport slave (
    output mic_data,
    output lrcl_clk,
    input  left_out,
    input  right_out,
    input  data_valid_out,
    input  frame_error_out
  );
endinterface

// File: rtl/i2s_rx_stereo.sv
// rtl/i2s_rx_stereo.sv - I2S stereo/mono receiver with slot-length checking
// i2s_clk : serial bit clock, the only clock (posedge)
// rst_n   : asynchronous active-low reset
// bus     : i2s_rx_stereo_if.master (mic_data, lrcl_clk in; samples and pulses out)
module i2s_rx_stereo #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SLOT_WIDTH   = 32,
  parameter int DATA_DELAY   = 1,
  parameter int MONO         = 0
) (
  input  logic                   i2s_clk,
  input  logic                   rst_n,
  i2s_rx_stereo_if.master        bus
);

  localparam int CW = $clog2(SLOT_WIDTH + 2);
  // Counter can reach at least SLOT_WIDTH+1, so a saturated count never
  // looks like a good slot.
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] SLOT_LEN = CW'(SLOT_WIDTH);
  localparam logic [CW-1:0] SAMP_LEN = CW'(SAMPLE_WIDTH);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  state_t                  state_q, state_d;
  logic                    prev_ws;
  logic [CW-1:0]           cnt, cnt_d;
  logic [SAMPLE_WIDTH-1:0] sr, sr_d;
  logic [SAMPLE_WIDTH-1:0] pend_q, pend_d;
  logic                    left_ok_q, left_ok_d;
  logic [SAMPLE_WIDTH-1:0] left_q, left_d;
  logic [SAMPLE_WIDTH-1:0] right_q, right_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic                    ws_edge, ws_fall, ws_rise, slot_ok, take;
  logic [CW-1:0]           cnt_m1;
  logic [SAMPLE_WIDTH:0]   sr_ext;
  logic [SAMPLE_WIDTH-1:0] shifted, closing_val;

  assign ws_edge = (bus.lrcl_clk != prev_ws);
  assign ws_fall = ws_edge && !bus.lrcl_clk;
  assign ws_rise = ws_edge && bus.lrcl_clk;
  // Pre-update count at an edge cycle is the length of the closing slot.
  assign slot_ok = (cnt == SLOT_LEN);
  assign cnt_m1  = cnt - CNT_ONE;
  assign sr_ext  = {sr, bus.mic_data};
  assign shifted = sr_ext[SAMPLE_WIDTH-1:0];

  // Datapath: bit capture and slot counter.
  always_comb begin
    take        = 1'b0;
    closing_val = sr;
    sr_d        = sr;
    cnt_d       = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    if (ws_edge) begin
      cnt_d = CNT_ONE;
    end
    if (DATA_DELAY != 0) begin
      // Bit k sits at count k+1; at an edge cycle this is the closing
      // slot's last bit, so it is folded into the closing value.
      take = (cnt != '0) && (cnt_m1 < SAMP_LEN);
      if (take) begin
        closing_val = shifted;
      end
      sr_d = ws_edge ? '0 : (take ? shifted : sr);
    end else begin
      // Bit k sits at count k; the edge cycle carries bit 0 of the new slot.
      take = ws_edge || (cnt < SAMP_LEN);
      if (ws_edge) begin
        sr_d = SAMPLE_WIDTH'(bus.mic_data);
      end else if (take) begin
        sr_d = shifted;
      end
    end
  end

  // Framing state machine and emission decisions.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    left_ok_d = left_ok_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      SYNC: begin
        if (ws_fall) begin
          state_d = LEFT;
        end
      end
      LEFT: begin
        if (ws_rise) begin
          state_d   = RIGHT;
          pend_d    = closing_val;
          left_ok_d = slot_ok;
          if (MONO != 0) begin
            if (slot_ok) begin
              left_d  = closing_val;
              valid_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      end
      RIGHT: begin
        if (ws_fall) begin
          state_d = LEFT;
          if (MONO != 0) begin
            err_d = !slot_ok;
          end else if (left_ok_q && slot_ok) begin
            left_d  = pend_q;
            right_d = closing_val;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge i2s_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= SYNC;
      prev_ws   <= 1'b0;
      cnt       <= '0;
      sr        <= '0;
      pend_q    <= '0;
      left_ok_q <= 1'b0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_ws   <= bus.lrcl_clk;
      cnt       <= cnt_d;
      sr        <= sr_d;
      pend_q    <= pend_d;
      left_ok_q <= left_ok_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.left_out        = left_q;
  assign bus.right_out       = right_q;
  assign bus.data_valid_out  = valid_q;
  assign bus.frame_error_out = err_q;

endmodule

// File: tb/tb_i2s_rx_stereo.sv
// tb/tb_i2s_rx_stereo.sv - directed bench for i2s_rx_stereo in four configurations
module tb_i2s_rx_stereo;

  logic i2s_clk = 1'b0;
  always #5 i2s_clk = ~i2s_clk;

  logic        ws_d  [4];
  logic        sd_d  [4];
  logic        rst_d [4];
  logic [23:0] lo    [4];
  logic [23:0] ro    [4];
  logic        v     [4];
  logic        e     [4];

  int   nv[4], ne[4], nbad[4];
  logic pw[4], cw[4], carry[4];
  int   ntot, npass;

  // 0: stereo I2S 16/32   1: left-justified 16/32
  // 2: mono I2S 16/32     3: stereo I2S 24/24
  i2s_rx_stereo_if #(.SAMPLE_WIDTH(16)) if0 ();
  i2s_rx_stereo_if #(.SAMPLE_WIDTH(16)) if1 ();
  i2s_rx_stereo_if #(.SAMPLE_WIDTH(16)) if2 ();
  i2s_rx_stereo_if #(.SAMPLE_WIDTH(24)) if3 ();

  i2s_rx_stereo #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .DATA_DELAY(1), .MONO(0))
    dut0 (.i2s_clk(i2s_clk), .rst_n(rst_d[0]), .bus(if0));
  i2s_rx_stereo #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .DATA_DELAY(0), .MONO(0))
    dut1 (.i2s_clk(i2s_clk), .rst_n(rst_d[1]), .bus(if1));
  i2s_rx_stereo #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(32), .DATA_DELAY(1), .MONO(1))
    dut2 (.i2s_clk(i2s_clk), .rst_n(rst_d[2]), .bus(if2));
  i2s_rx_stereo #(.SAMPLE_WIDTH(24), .SLOT_WIDTH(24), .DATA_DELAY(1), .MONO(0))
    dut3 (.i2s_clk(i2s_clk), .rst_n(rst_d[3]), .bus(if3));

  assign if0.lrcl_clk = ws_d[0];  assign if0.mic_data = sd_d[0];
  assign if1.lrcl_clk = ws_d[1];  assign if1.mic_data = sd_d[1];
  assign if2.lrcl_clk = ws_d[2];  assign if2.mic_data = sd_d[2];
  assign if3.lrcl_clk = ws_d[3];  assign if3.mic_data = sd_d[3];

  assign lo[0] = 24'(if0.left_out);  assign ro[0] = 24'(if0.right_out);
  assign lo[1] = 24'(if1.left_out);  assign ro[1] = 24'(if1.right_out);
  assign lo[2] = 24'(if2.left_out);  assign ro[2] = 24'(if2.right_out);
  assign lo[3] = if3.left_out;       assign ro[3] = if3.right_out;
  assign v[0] = if0.data_valid_out;  assign e[0] = if0.frame_error_out;
  assign v[1] = if1.data_valid_out;  assign e[1] = if1.frame_error_out;
  assign v[2] = if2.data_valid_out;  assign e[2] = if2.frame_error_out;
  assign v[3] = if3.data_valid_out;  assign e[3] = if3.frame_error_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      npass++;
  endtask

  // One bit clock for instance s: account for the pulses produced by the
  // previously driven cycle, then drive the next ws/data values.
  task automatic cyc(input int s, input logic w, input logic d);
    logic close_edge;
    @(negedge i2s_clk);
    close_edge = (s == 2) ? (!pw[s] && cw[s]) : (pw[s] && !cw[s]);
    if (v[s]) nv[s]++;
    if (e[s]) ne[s]++;
    if (v[s] && e[s]) nbad[s]++;
    else if (v[s] && !close_edge) nbad[s]++;
    pw[s]   = cw[s];
    cw[s]   = w;
    ws_d[s] = w;
    sd_d[s] = d;
  endtask

  // One slot; word holds slot bit k at word[63-k].
  task automatic slot(input int s, input logic w, input logic [63:0] word, input int len);
    bit dd;
    dd = (s != 1);
    for (int j = 0; j < len; j++) begin
      logic b;
      if (dd) b = (j == 0) ? carry[s] : word[64-j];
      else    b = word[63-j];
      cyc(s, w, b);
    end
    if (dd) carry[s] = word[64-len];
  endtask

  initial begin
    ntot = 0;
    npass = 0;
    for (int i = 0; i < 4; i++) begin
      ws_d[i] = 1'b0; sd_d[i] = 1'b0; rst_d[i] = 1'b0;
      nv[i] = 0; ne[i] = 0; nbad[i] = 0;
      pw[i] = 1'b0; cw[i] = 1'b0; carry[i] = 1'b0;
    end
    repeat (3) @(negedge i2s_clk);
    check("rst_left",  lo[0], 0);
    check("rst_right", ro[0], 0);
    check("rst_valid", v[0], 0);
    check("rst_error", e[0], 0);
    for (int i = 0; i < 4; i++) rst_d[i] = 1'b1;

    // Stereo lock, capture and short left slot.
    slot(0, 1'b1, 64'hFFFF_FFFF_0000_0000, 10);
    slot(0, 1'b0, 64'h1234_5678_0000_0000, 32);
    check("a_partial_valid", nv[0], 0);
    check("a_partial_error", ne[0], 0);
    slot(0, 1'b1, 64'hABCD_9876_0000_0000, 32);
    slot(0, 1'b0, 64'h1234_5678_0000_0000, 32);
    check("a_f1_count", nv[0], 1);
    slot(0, 1'b1, 64'hABCD_9876_0000_0000, 32);
    slot(0, 1'b0, 64'h5555_5555_0000_0000, 31);
    check("a_f2_count", nv[0], 2);
    check("a_f2_left",  lo[0], 16'h1234);
    check("a_f2_right", ro[0], 16'hABCD);
    slot(0, 1'b1, 64'h6666_6666_0000_0000, 32);
    slot(0, 1'b0, 64'h1111_0000_0000_0000, 32);
    check("a_short_error", ne[0], 1);
    check("a_short_valid", nv[0], 2);
    check("a_short_left",  lo[0], 16'h1234);
    check("a_short_right", ro[0], 16'hABCD);
    slot(0, 1'b1, 64'h2222_0000_0000_0000, 32);
    slot(0, 1'b0, 64'h3333_0000_0000_0000, 32);
    check("a_recover_count", nv[0], 3);
    check("a_recover_left",  lo[0], 16'h1111);
    check("a_recover_right", ro[0], 16'h2222);
    check("a_timing", nbad[0], 0);

    // Reset halfway through a right slot.
    slot(0, 1'b1, 64'h4321_0000_0000_0000, 16);
    #2 rst_d[0] = 1'b0;
    #1;
    check("a_rst_left",  lo[0], 0);
    check("a_rst_right", ro[0], 0);
    check("a_rst_valid", v[0], 0);
    repeat (3) cyc(0, 1'b1, 1'b0);
    rst_d[0] = 1'b1;
    slot(0, 1'b1, 64'hFFFF_FFFF_0000_0000, 10);
    slot(0, 1'b0, 64'h4444_0000_0000_0000, 32);
    slot(0, 1'b1, 64'h7777_0000_0000_0000, 32);
    check("a_resync_quiet", nv[0], 3);
    check("a_resync_left0", lo[0], 0);
    slot(0, 1'b0, 64'h9999_0000_0000_0000, 32);
    check("a_resync_count", nv[0], 4);
    check("a_resync_left",  lo[0], 16'h4444);
    check("a_resync_right", ro[0], 16'h7777);
    check("a_error_total",  ne[0], 1);

    // Left-justified framing.
    slot(1, 1'b1, 64'h0, 10);
    slot(1, 1'b0, 64'h8001_A5A5_0000_0000, 32);
    slot(1, 1'b1, 64'h7FFF_5A5A_0000_0000, 32);
    slot(1, 1'b0, 64'h8001_A5A5_0000_0000, 32);
    slot(1, 1'b1, 64'h7FFF_5A5A_0000_0000, 32);
    slot(1, 1'b0, 64'h0, 32);
    check("b_count", nv[1], 2);
    check("b_left",  lo[1], 16'h8001);
    check("b_right", ro[1], 16'h7FFF);
    check("b_error", ne[1], 0);
    check("b_timing", nbad[1], 0);

    // Mono: emission after each left slot, right data ignored.
    slot(2, 1'b1, 64'h0, 10);
    slot(2, 1'b0, 64'h0F0F_1234_0000_0000, 32);
    slot(2, 1'b1, 64'hFFFF_FFFF_0000_0000, 32);
    check("c_f1_count", nv[2], 1);
    check("c_f1_left",  lo[2], 16'h0F0F);
    slot(2, 1'b0, 64'h0F0F_4321_0000_0000, 32);
    slot(2, 1'b1, 64'hFFFF_FFFF_0000_0000, 32);
    check("c_count",  nv[2], 2);
    check("c_right",  ro[2], 0);
    check("c_error",  ne[2], 0);
    check("c_timing", nbad[2], 0);

    // Sample width equal to slot width; LSB arrives on the closing edge.
    slot(3, 1'b1, 64'h0, 10);
    slot(3, 1'b0, 64'hC00001 << 40, 24);
    slot(3, 1'b1, 64'h123456 << 40, 24);
    slot(3, 1'b0, 64'h0, 24);
    check("d_count", nv[3], 1);
    check("d_left",  lo[3], 24'hC00001);
    check("d_right", ro[3], 24'h123456);
    check("d_error", ne[3], 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
